// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package riscv_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory request/response plus the decode handshake.
interface instr_fetch_unit_if;
    import riscv_fetch_pkg::*;

    logic               imem_req_valid;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [XLEN-1:0]    instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with flush; used for both the prefetch queue and the in-flight PC queue.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    // a pop in the same cycle frees the slot, so a full queue can still accept
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, prefetches into a small queue, handles redirects.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_redirect,
`endif
    instr_fetch_unit_if.master bus
);
    // state | meaning
    // BOOT  | first cycle out of reset, no requests
    // RUN   | normal prefetch, requests issued while queue + in-flight < DEPTH
    // DRAIN | redirect taken with responses in flight; discarding them

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            pend_q;
    logic            pend_stale_q;
    logic [XLEN-1:0] pend_addr_q;

    logic            dq_full, dq_empty;
    logic [CW-1:0]   dq_count;
    fetch_entry_t    dq_head;
    logic            pcq_full, pcq_empty;
    logic [CW-1:0]   pcq_count;
    logic [XLEN-1:0] pcq_head;

    logic            deq;
    logic            room;
    logic            req_new;
    logic            req_valid;
    logic            req_fire;
    logic            req_stale;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            enq;
    logic [CW-1:0]   out_after_rsp;
    logic [CW-1:0]   out_next;

    assign deq  = bus.instr_valid && bus.instr_ready;
    // the slot freed by this cycle's dequeue is counted so steady state has no bubbles
    assign room = ({1'b0, dq_count} + {1'b0, pcq_count}) < (SW'(DEPTH) + SW'(deq));

    assign req_new   = (state_q == RUN) && room && !pcq_full;
    assign req_valid = pend_q || req_new;
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign req_stale = pend_q && pend_stale_q;

    assign rsp_fire = bus.imem_rsp_valid && !pcq_empty;
    assign rsp_drop = rsp_fire && (drop_q != '0);
    assign enq      = rsp_fire && !rsp_drop && !redirect_valid && (!dq_full || deq);

    assign out_after_rsp = pcq_count - CW'(rsp_fire);
    assign out_next      = out_after_rsp + CW'(req_fire);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pend_q ? pend_addr_q : fetch_pc_q;
    assign bus.instr_valid    = !dq_empty;
    assign bus.instr_data     = dq_empty ? NOP_INSTR : dq_head.instr;
    assign bus.instr_pc       = dq_empty ? RESET_PC  : dq_head.pc;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W + XLEN)) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (deq),
        .wdata ({bus.imem_rsp_data, pcq_head}),
        .rdata (dq_head),
        .full  (dq_full),
        .empty (dq_empty),
        .count (dq_count)
    );

    // one entry per accepted request, popped by every response including dropped ones
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .pop   (rsp_fire),
        .wdata (bus.imem_req_addr),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;

        if (rsp_drop)
            drop_d = drop_d - CW'(1);
        if (req_fire && req_stale)
            drop_d = drop_d + CW'(1);
        if (req_fire && !req_stale)
            fetch_pc_d = fetch_pc_q + 32'd4;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_valid && (out_after_rsp != '0)) state_d = DRAIN;
            DRAIN:   if (drop_q == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            if (state_q != DRAIN)
                drop_d = out_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    // an unaccepted request keeps its address; a redirect marks it stale so its response is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q       <= 1'b0;
            pend_stale_q <= 1'b0;
            pend_addr_q  <= RESET_PC;
        end else if (req_valid && !bus.imem_req_ready) begin
            pend_q       <= 1'b1;
            pend_stale_q <= req_stale || redirect_valid;
            pend_addr_q  <= bus.imem_req_addr;
        end else begin
            pend_q       <= 1'b0;
            pend_stale_q <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched  <= '0;
            perf_stall    <= '0;
            perf_redirect <= '0;
        end else begin
            if (enq && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (bus.instr_ready && !bus.instr_valid && (state_q != BOOT) && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
            if (redirect_valid && (perf_redirect != '1))
                perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency memory model.
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_redirect;
`endif

    instr_fetch_unit_if bus();

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_redirect  (perf_redirect),
`endif
        .bus            (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat   = 1;
    int          cyc   = 0;
    int          base  = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_log[$];

    // memory word is the address xor a tag, so expected data is easy to compute by hand
    always @(posedge clk) begin
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 32'h0;
        end else begin
            if (bus.imem_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq_addr.push_back(bus.imem_req_addr);
                mq_due.push_back(cyc + lat);
                acc_log.push_back(bus.imem_req_addr);
            end
            if (mq_due.size() > 0 && mq_due[0] <= cyc + 1) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= mq_addr[0] ^ 32'hC0DE_0000;
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic wait_valid(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles && !bus.instr_valid; i++) step();
        chk(tag, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    task automatic do_reset(input int latency, input logic req_rdy, input logic ins_rdy);
        rst = 1'b0;
        lat = latency;
        bus.imem_req_ready = req_rdy;
        bus.instr_ready    = ins_rdy;
        step();
        step();
        rst  = 1'b1;
        base = acc_log.size();
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;

        // reset values
        rst = 1'b0;
        step();
        step();
        chk("rst_req_valid",   {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, bus.instr_valid},    32'd0);
        chk("rst_req_addr",    bus.imem_req_addr,           32'h0000_0000);
        chk("rst_instr_data",  bus.instr_data,              32'h0000_0013);
        chk("rst_instr_pc",    bus.instr_pc,                32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched",  perf_fetched,  32'h0);
        chk("rst_perf_stall",    perf_stall,    32'h0);
        chk("rst_perf_redirect", perf_redirect, 32'h0);
`endif

        // streaming from reset, 1-cycle memory
        rst = 1'b1;
        step();
        chk("boot_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("boot_req_addr0", bus.imem_req_addr, 32'h0000_0000);
        step();
        chk("boot_req_addr4", bus.imem_req_addr, 32'h0000_0004);
        step();
        chk("stream_valid0", {31'b0, bus.instr_valid}, 32'd1);
        chk("stream_pc0",    bus.instr_pc,   32'h0000_0000);
        chk("stream_data0",  bus.instr_data, 32'hC0DE_0000);
        step();
        chk("stream_valid1", {31'b0, bus.instr_valid}, 32'd1);
        chk("stream_pc1",    bus.instr_pc, 32'h0000_0004);
        step();
        chk("stream_pc2",    bus.instr_pc, 32'h0000_0008);

        // backpressure: only DEPTH requests, then ordered release
        do_reset(1, 1'b1, 1'b0);
        repeat (10) step();
        chk("stall_req_count", 32'(acc_log.size() - base), 32'd2);
        chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("stall_pc0",       bus.instr_pc, 32'h0000_0000);
        bus.instr_ready = 1'b1;
        step();
        chk("release_pc4", bus.instr_pc, 32'h0000_0004);
        step();
        chk("release_pc8",   bus.instr_pc,   32'h0000_0008);
        chk("release_data8", bus.instr_data, 32'hC0DE_0008);
        chk("release_acc8",  acc_at(base + 2), 32'h0000_0008);

        // redirect with two responses in flight
        do_reset(4, 1'b1, 1'b1);
        step();
        step();
        step();
        chk("inflight_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        lat = 1;
        chk("drain_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("drain_req_valid",   {31'b0, bus.imem_req_valid}, 32'd0);
        wait_valid(30, "drain_timeout");
        chk("drain_first_pc",   bus.instr_pc,   32'h0000_0100);
        chk("drain_first_data", bus.instr_data, 32'hC0DE_0100);
        step();
        chk("drain_next_pc",  bus.instr_pc, 32'h0000_0104);
        chk("drain_acc_tgt",  acc_at(base + 2), 32'h0000_0100);

        // misaligned target and redirect while a request is held off
        do_reset(1, 1'b0, 1'b1);
        step();
        step();
        step();
        chk("hold_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        chk("hold_req_valid2", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("hold_req_addr",   bus.imem_req_addr, 32'h0000_0000);
        bus.imem_req_ready = 1'b1;
        wait_valid(20, "hold_timeout");
        chk("hold_first_pc",   bus.instr_pc,   32'h0000_0200);
        chk("hold_first_data", bus.instr_data, 32'hC0DE_0200);
        chk("hold_acc0",       acc_at(base),     32'h0000_0000);
        chk("hold_acc1",       acc_at(base + 1), 32'h0000_0200);

        // redirect coinciding with a dequeue of a full queue
        do_reset(1, 1'b1, 1'b0);
        repeat (6) step();
        chk("full_pc0", bus.instr_pc, 32'h0000_0000);
        bus.instr_ready = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        chk("flush_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        wait_valid(20, "flush_timeout");
        chk("flush_first_pc", bus.instr_pc, 32'h0000_0040);
        step();
        chk("flush_next_pc",  bus.instr_pc, 32'h0000_0044);

        // address wrap
        bus.instr_ready = 1'b0;
        repeat (6) step();
        base           = acc_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid  = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (8) step();
        chk("wrap_acc0", acc_at(base),     32'hFFFF_FFF8);
        chk("wrap_acc1", acc_at(base + 1), 32'hFFFF_FFFC);
        chk("wrap_acc2", acc_at(base + 2), 32'h0000_0000);

        // reset with responses in flight
        lat = 4;
        repeat (6) step();
        rst = 1'b0;
        step();
        chk("midrst_instr_valid", {31'b0, bus.instr_valid},    32'd0);
        chk("midrst_req_valid",   {31'b0, bus.imem_req_valid}, 32'd0);
        chk("midrst_req_addr",    bus.imem_req_addr,           32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst_perf_fetched",  perf_fetched,  32'h0);
        chk("midrst_perf_stall",    perf_stall,    32'h0);
        chk("midrst_perf_redirect", perf_redirect, 32'h0);
`endif
        lat  = 1;
        rst  = 1'b1;
        base = acc_log.size();
        wait_valid(20, "midrst_timeout");
        chk("midrst_first_pc",   bus.instr_pc,   32'h0000_0000);
        chk("midrst_first_data", bus.instr_data, 32'hC0DE_0000);
        chk("midrst_acc0",       acc_at(base),   32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
